// File: rtl/au_multiword_sequencer.sv
// -----------------------------------------------------------------------------
// au_multiword_sequencer
//
// Wraps a W-bit combinational ripple-carry arithmetic unit so that it can
// compute ADD, SUB, ADC and SBC on W*N_WORDS-bit operands.
//
// One operand pair is accepted per transaction. The operands are then fed to
// the arithmetic unit one W-bit word per clock, least-significant word first.
// The carry between words is chained through a register. The full-width result
// and its flags are then held for downstream until it accepts them.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (accepted when both are high)
//   op                    00 ADD, 01 SUB, 10 ADC, 11 SBC
//   cin                   carry input, used by ADC/SBC only
//   x, y                  TW-bit operands A and B
//   au_a, au_b, au_cin    word, (possibly inverted) word and carry driven to
//                         the arithmetic unit; all 0 outside RUN
//   au_soma, au_cout      same-cycle sum and carry from the arithmetic unit
//   out_valid / out_ready result handshake
//   result                registered TW-bit sum or difference
//   carry_out             final carry; for SUB/SBC, 1 = no borrow
//   overflow              signed two's-complement overflow
//   zero                  result == 0
// -----------------------------------------------------------------------------
module au_multiword_sequencer #(
  parameter int W       = 6,
  parameter int N_WORDS = 2,
  parameter int TW      = W * N_WORDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    op,
  input  logic          cin,
  input  logic [TW-1:0] x,
  input  logic [TW-1:0] y,
  output logic [W-1:0]  au_a,
  output logic [W-1:0]  au_b,
  output logic          au_cin,
  input  logic [W-1:0]  au_soma,
  input  logic          au_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] result,
  output logic          carry_out,
  output logic          overflow,
  output logic          zero
);

  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_x;
  logic [TW-1:0]   r_y;
  logic [1:0]      r_op;
  logic            r_cin;
  logic            r_carry;
  logic [TW-1:0]   r_result;
  logic            r_carry_out;
  logic            r_overflow;
  logic            r_zero;

  logic            w_accept;
  logic            w_release;
  logic            w_last;
  logic            w_invert;
  logic [W-1:0]    w_x_word;
  logic [W-1:0]    w_y_word;
  logic [W-1:0]    w_b_eff;
  logic            w_cin_eff;
  logic [TW-1:0]   w_result_next;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_release = (r_state == DONE) && out_ready;
  assign w_last    = (r_idx == IW'(N_WORDS - 1));

  // SUB (01) and SBC (11) both subtract: B is inverted whenever op[0] is set.
  assign w_invert  = r_op[0];

  // Select the current word of each latched operand. The result copy with the
  // current word replaced lets the zero flag see the complete new value.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_x_word      = '0;
    w_y_word      = '0;
    w_result_next = r_result;
    for (int k = 0; k < N_WORDS; k++) begin
      if (r_idx == IW'(k)) begin
        w_x_word                = r_x[k*W +: W];
        w_y_word                = r_y[k*W +: W];
        w_result_next[k*W +: W] = au_soma;
      end
    end
  end

  assign w_b_eff = w_invert ? ~w_y_word : w_y_word;

  // Word 0 carry: ADD=0, SUB=1, ADC/SBC=latched cin. Later words: chained carry.
  always_comb begin
    w_cin_eff = r_carry;
    if (r_idx == '0) begin
      w_cin_eff = r_op[1] ? r_cin : r_op[0];
    end
  end

  // Next-state logic and arithmetic-unit drive.
  always_comb begin
    w_state_next = r_state;
    au_a         = '0;
    au_b         = '0;
    au_cin       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = RUN;
      end
      RUN: begin
        au_a   = w_x_word;
        au_b   = w_b_eff;
        au_cin = w_cin_eff;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        if (w_release) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the operand latches and result are reset along with the control
  // state. This ensures that an aborted transaction never leaves stale
  // values visible on result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_op        <= 2'b00;
      r_cin       <= 1'b0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x   <= x;
        r_y   <= y;
        r_op  <= op;
        r_cin <= cin;
        r_idx <= '0;
      end
      if (r_state == RUN) begin
        r_result <= w_result_next;
        r_carry  <= au_cout;
        r_idx    <= r_idx + IW'(1);
        if (w_last) begin
          r_carry_out <= au_cout;
          r_overflow  <= (au_a[W-1] == au_b[W-1]) && (au_soma[W-1] != au_a[W-1]);
          r_zero      <= (w_result_next == '0);
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_au_multiword_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for au_multiword_sequencer (W=6, N_WORDS=2, TW=12).
// The bench plays the role of the 6-bit arithmetic unit. It drives inputs on
// the falling edge and samples outputs there as well.
// -----------------------------------------------------------------------------
module tb_au_multiword_sequencer;

  localparam int W       = 6;
  localparam int N_WORDS = 2;
  localparam int TW      = W * N_WORDS;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic          cin;
  logic [TW-1:0] x;
  logic [TW-1:0] y;
  logic [W-1:0]  au_a;
  logic [W-1:0]  au_b;
  logic          au_cin;
  logic [W-1:0]  au_soma;
  logic          au_cout;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] result;
  logic          carry_out;
  logic          overflow;
  logic          zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Combinational 6-bit arithmetic unit.
  assign {au_cout, au_soma} = au_a + au_b + au_cin;

  au_multiword_sequencer #(.W(W), .N_WORDS(N_WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .cin       (cin),
    .x         (x),
    .y         (y),
    .au_a      (au_a),
    .au_b      (au_b),
    .au_cin    (au_cin),
    .au_soma   (au_soma),
    .au_cout   (au_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  typedef struct {
    logic [1:0]    op;
    logic          cin;
    logic [TW-1:0] x;
    logic [TW-1:0] y;
    logic [TW-1:0] exp_res;
    logic          exp_c;
    logic          exp_v;
    logic          exp_z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a transaction from IDLE and follow it through both words into DONE,
  // checking the arithmetic-unit drive each cycle.
  task automatic start_txn(input vec_t v);
    logic [W-1:0] a0, b0, a1, b1;
    logic         c0, c1;
    logic [W:0]   s0;
    a0 = v.x[W-1:0];
    a1 = v.x[TW-1:W];
    b0 = v.op[0] ? ~v.y[W-1:0] : v.y[W-1:0];
    b1 = v.op[0] ? ~v.y[TW-1:W] : v.y[TW-1:W];
    c0 = v.op[1] ? v.cin : v.op[0];
    s0 = a0 + b0 + c0;
    c1 = s0[W];

    @(negedge clk);
    check("idle in_ready", in_ready, 1);
    check("idle out_valid", out_valid, 0);
    check("idle au drive", {au_a, au_b, au_cin}, 0);
    op = v.op; cin = v.cin; x = v.x; y = v.y; in_valid = 1'b1;

    @(negedge clk);
    // Operand changes after acceptance must have no effect.
    in_valid = 1'b0; x = ~v.x; y = ~v.y; op = ~v.op; cin = ~v.cin;
    check("run0 in_ready", in_ready, 0);
    check("run0 out_valid", out_valid, 0);
    check("run0 au drive", {au_a, au_b, au_cin}, {a0, b0, c0});

    @(negedge clk);
    check("run1 out_valid", out_valid, 0);
    check("run1 au drive", {au_a, au_b, au_cin}, {a1, b1, c1});

    @(negedge clk);
    check("done out_valid", out_valid, 1);
    check("done in_ready", in_ready, 0);
    check("done au drive", {au_a, au_b, au_cin}, 0);
  endtask

  task automatic finish_txn(input vec_t v);
    check("result", result, v.exp_res);
    check("carry_out", carry_out, v.exp_c);
    check("overflow", overflow, v.exp_v);
    check("zero", zero, v.exp_z);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release out_valid", out_valid, 0);
    check("release in_ready", in_ready, 1);
    check("result retained", result, v.exp_res);
  endtask

  initial begin
    vec_t v;
    //                op      cin   x       y       res     c     v     z
    vecs[0] = '{OP_ADD, 1'b0, 12'h0C5, 12'h03B, 12'h100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{OP_ADD, 1'b0, 12'hFFF, 12'h001, 12'h000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{OP_ADC, 1'b1, 12'h03F, 12'h000, 12'h040, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{OP_SUB, 1'b0, 12'h800, 12'h001, 12'h7FF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{OP_SUB, 1'b0, 12'h005, 12'h006, 12'hFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_SBC, 1'b0, 12'h100, 12'h001, 12'h0FE, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{OP_ADC, 1'b0, 12'h7FF, 12'h001, 12'h800, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{OP_SBC, 1'b1, 12'h000, 12'h000, 12'h000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{OP_ADD, 1'b1, 12'h001, 12'h001, 12'h002, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{OP_SUB, 1'b0, 12'h123, 12'h123, 12'h000, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; cin = 1'b0; x = '0; y = '0;

    // Reset state.
    #12;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset flags", {carry_out, overflow, zero}, 0);
    check("reset au drive", {au_a, au_b, au_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven transactions.
    for (int i = 0; i < 10; i++) begin
      start_txn(vecs[i]);
      finish_txn(vecs[i]);
    end

    // Backpressure: hold the result while a new request is offered.
    start_txn(vecs[0]);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; op = OP_ADD; x = 12'h111; y = 12'h222;
      @(negedge clk);
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      check("bp result", result, 12'h100);
      check("bp flags", {carry_out, overflow, zero}, 3'b000);
      check("bp au drive", {au_a, au_b, au_cin}, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp release out_valid", out_valid, 0);
    check("bp release in_ready", in_ready, 1);
    check("bp request not taken", result, 12'h100);
    v = '{OP_ADD, 1'b0, 12'h111, 12'h222, 12'h333, 1'b0, 1'b0, 1'b0};
    start_txn(v);
    finish_txn(v);

    // Reset mid-RUN, right after word 0 has been written.
    @(negedge clk);
    op = OP_ADD; cin = 1'b0; x = 12'h0C1; y = 12'h001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre-reset low word", result[W-1:0], 6'h02);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 1);
    check("abort result", result, 0);
    check("abort au drive", {au_a, au_b, au_cin}, 0);
    @(negedge clk);
    check("abort held out_valid", out_valid, 0);
    rst_n = 1'b1;
    start_txn(vecs[0]);
    finish_txn(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
